coreahbtoapb3_apb3_responder: RTL

- APB3 completer that sits on the APB side of the AHB-to-APB3 bridge; the other end of the bridge's PSEL/PENABLE sequencing.
- Holds a small 32-bit register bank and answers transfers with a fixed number of wait states (PREADY).
- Raises PSLVERR on illegal accesses and flags master-side protocol violations.
- Used as the standard bridge test target and as a reusable config-register block.

---
 rtl/coreahbtoapb3_apb3_responder_pkg.sv | 13 +
 rtl/coreahbtoapb3_apb3_regbank.sv | 52 +++++
 rtl/coreahbtoapb3_apb3_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/coreahbtoapb3_apb3_responder_pkg.sv
// Shared constants for the APB3 responder slice.
// State codes, data width and default ID word.
package coreahbtoapb3_apb3_responder_pkg;

  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] DEF_ID_VALUE = 32'hA5B3_0001;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/coreahbtoapb3_apb3_regbank.sv
// Register array for the APB3 responder.
// Index 0 is the constant ID word; 1..NUM_REGS-1 are writable.
module coreahbtoapb3_apb3_regbank
  import coreahbtoapb3_apb3_responder_pkg::*;
#(
  parameter int                IDX_W    = 10,
  parameter int                NUM_REGS = 8,
  parameter logic [APB_DW-1:0] ID_VALUE = DEF_ID_VALUE
) (
  input  logic                         HCLK,
  input  logic                         HRESETN,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [APB_DW-1:0]            wdata,
  input  logic [IDX_W-1:0]             ridx,
  output logic [APB_DW-1:0]            rdata,
  output logic                         ridx_ok,
  output logic [NUM_REGS*APB_DW-1:0]   regs_out
);

  logic [APB_DW-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (widx == IDX_W'(i))
          regs[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (ridx == '0)
      rdata = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      if (ridx == IDX_W'(i))
        rdata = regs[i];
  end

  assign ridx_ok = (32'(ridx) < 32'(NUM_REGS));

  always_comb begin
    regs_out = '0;
    regs_out[APB_DW-1:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      regs_out[i*APB_DW +: APB_DW] = regs[i];
  end

endmodule

// File: rtl/coreahbtoapb3_apb3_responder.sv
// APB3 completer: register bank with fixed wait states,
// PSLVERR on illegal accesses and a sticky protocol-error flag.
module coreahbtoapb3_apb3_responder
  import coreahbtoapb3_apb3_responder_pkg::*;
#(
  parameter int                ADDR_WIDTH  = 12,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [APB_DW-1:0] ID_VALUE    = DEF_ID_VALUE
) (
  input  logic                        HCLK,
  input  logic                        HRESETN,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_WIDTH-1:0]       PADDR,
  input  logic [APB_DW-1:0]           PWDATA,
  output logic [APB_DW-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        PROTOERR,
  output logic [NUM_REGS*APB_DW-1:0]  REGS_OUT
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  c_wr;
  logic                  c_err;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [APB_DW-1:0]     c_data;

  logic [IDX_W-1:0]  idx;
  logic [APB_DW-1:0] rdata;
  logic              idx_ok;
  logic              dec_err;
  logic              setup;
  logic              access;
  logic              held;
  logic              we;
  logic [APB_DW-1:0] rsp_data;

  assign idx     = PADDR[ADDR_WIDTH-1:2];
  assign setup   = PSEL & ~PENABLE;
  assign access  = PSEL & PENABLE;
  assign held    = access & (PADDR == c_addr) & (PWRITE == c_wr);
  assign dec_err = ~idx_ok | (PWRITE & (idx == '0));

  // PADDR/PWRITE equal the captured values whenever a response is issued
  assign rsp_data = (dec_err | PWRITE) ? '0 : rdata;

  assign we = (state == ST_RESP) & held & c_wr & ~c_err;

  coreahbtoapb3_apb3_regbank #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .we       (we),
    .widx     (c_addr[ADDR_WIDTH-1:2]),
    .wdata    (c_data),
    .ridx     (idx),
    .rdata    (rdata),
    .ridx_ok  (idx_ok),
    .regs_out (REGS_OUT)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      c_wr     <= 1'b0;
      c_err    <= 1'b0;
      c_addr   <= '0;
      c_data   <= '0;
      PREADY   <= 1'b0;
      PRDATA   <= '0;
      PSLVERR  <= 1'b0;
      PROTOERR <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            PROTOERR <= 1'b1;
          end else if (setup) begin
            c_wr   <= PWRITE;
            c_addr <= PADDR;
            c_data <= PWDATA;
            c_err  <= dec_err;
            if (WAIT_STATES == 0) begin
              state   <= ST_RESP;
              PREADY  <= 1'b1;
              PSLVERR <= dec_err;
              PRDATA  <= rsp_data;
            end else begin
              cnt   <= 4'(WAIT_STATES);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!held) begin
            PROTOERR <= 1'b1;
            state    <= ST_IDLE;
          end else if (cnt == 4'd1) begin
            state   <= ST_RESP;
            PREADY  <= 1'b1;
            PSLVERR <= c_err;
            PRDATA  <= rsp_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (!held)
            PROTOERR <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
